group_leaf_router: RTL and testbench

Four-leaf group router that sits directly downstream of the per-GPU network interfaces (`ni`). It sits in the same GPU group of the hierarchical NoC. Each of the four NIs in a group, plus one uplink toward the spine, feeds a 16-bit flit into the router. The router routes on the 6-bit header (4-bit group, 2-bit leaf), buffers per input, and round-robin-arbitrates each output. Flits for the local group go to the addressed NI; all others go to the uplink.

---
 rtl/noc_pkg.sv | 59 +++++
 rtl/group_leaf_router_if.sv | 29 ++
 rtl/flit_fifo.sv | 56 +++++
 rtl/group_leaf_router.sv | 151 +++++++++++++++
 tb/tb_group_leaf_router.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit geometry, header field helpers, port indices
// and the round-robin pick used by router output arbiters. The same address
// map is used by the per-GPU network interfaces.
package noc_pkg;

   localparam int DATA_W    = 16;
   localparam int HEADER_W  = 6;
   localparam int LEAF_W    = 2;
   localparam int GROUP_W   = 4;
   localparam int LEAF_LSB  = DATA_W - HEADER_W;   // flit[11:10]
   localparam int GROUP_LSB = LEAF_LSB + LEAF_W;    // flit[15:12]

   // Router port indices: four leaves followed by the spine uplink.
   localparam int NUM_LEAVES = 4;
   localparam int NUM_PORTS  = NUM_LEAVES + 1;
   localparam int LEAF0      = 0;
   localparam int LEAF1      = 1;
   localparam int LEAF2      = 2;
   localparam int LEAF3      = 3;
   localparam int UPLINK     = 4;

   typedef logic [2:0] port_t;

   // Result of one arbitration: whether anything won, and which input.
   typedef struct packed {
      logic  found;
      port_t idx;
   } grant_t;

   function automatic logic [GROUP_W-1:0] hdr_group(input logic [DATA_W-1:0] flit);
      return flit[GROUP_LSB +: GROUP_W];
   endfunction

   function automatic logic [LEAF_W-1:0] hdr_leaf(input logic [DATA_W-1:0] flit);
      return flit[LEAF_LSB +: LEAF_W];
   endfunction

   // Round-robin pick: first requester at or after ptr, wrapping mod NUM_PORTS.
   // Walks from the farthest offset back to the nearest so the nearest wins.
   function automatic grant_t rr_pick(input logic [NUM_PORTS-1:0] req, input port_t ptr);
      grant_t g;
      int     c;
      g = '0;
      for (int off = NUM_PORTS - 1; off >= 0; off--) begin
         c = (int'(ptr) + off) % NUM_PORTS;
         if (req[c]) begin
            g.found = 1'b1;
            g.idx   = port_t'(c);
         end
      end
      return g;
   endfunction

   // Arbiter pointer after a grant to idx: one past the winner, wrapping.
   function automatic port_t next_ptr(input port_t idx);
      return (idx == port_t'(NUM_PORTS - 1)) ? port_t'(0) : idx + port_t'(1);
   endfunction

endpackage

// File: rtl/group_leaf_router_if.sv
// Flit bus between the router and its four NIs plus the spine uplink.
// master = the network side feeding the router; slave = the router itself.
interface group_leaf_router_if #(
   parameter int DATA_W = noc_pkg::DATA_W
);
   logic [noc_pkg::NUM_LEAVES*DATA_W-1:0] leaf_data_in;
   logic [noc_pkg::NUM_LEAVES-1:0]        leaf_valid_in;
   logic [noc_pkg::NUM_LEAVES-1:0]        leaf_ready_out;
   logic [noc_pkg::NUM_LEAVES*DATA_W-1:0] leaf_data_out;
   logic [noc_pkg::NUM_LEAVES-1:0]        leaf_valid_out;
   logic [DATA_W-1:0]                     up_data_in;
   logic                                  up_valid_in;
   logic                                  up_ready_out;
   logic [DATA_W-1:0]                     up_data_out;
   logic                                  up_valid_out;
   logic                                  up_ready_in;

   modport master (
      output leaf_data_in, leaf_valid_in, up_data_in, up_valid_in, up_ready_in,
      input  leaf_ready_out, leaf_data_out, leaf_valid_out,
             up_ready_out, up_data_out, up_valid_out
   );

   modport slave (
      input  leaf_data_in, leaf_valid_in, up_data_in, up_valid_in, up_ready_in,
      output leaf_ready_out, leaf_data_out, leaf_valid_out,
             up_ready_out, up_data_out, up_valid_out
   );
endinterface

// File: rtl/flit_fifo.sv
// Synchronous flit FIFO with occupancy count. Pushes while full and pops
// while empty are ignored; push and pop together leave the count unchanged.
module flit_fifo #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           push,
   input  logic [DATA_W-1:0]              push_data,
   input  logic                           pop,
   output logic [DATA_W-1:0]              head,
   output logic [$clog2(DEPTH+1)-1:0]     count,
   output logic                           full,
   output logic                           empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; DEPTH is a power of 2 so pointers wrap naturally.
   // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Flit storage write port.
   // NOTE: storage is deliberately not reset; count/pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/group_leaf_router.sv
// Four-leaf group router: per-input FIFOs, header routing at each FIFO head,
// and an independent round-robin arbiter per output (4 leaves + uplink).
module group_leaf_router #(
   parameter logic [3:0] GROUP_ID   = 4'd4,
   parameter int         DATA_W     = noc_pkg::DATA_W,
   parameter int         HEADER_W   = noc_pkg::HEADER_W,
   parameter int         FIFO_DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   group_leaf_router_if.slave             bus,
   output logic [noc_pkg::NUM_PORTS-1:0]  drop_pulse
);
   import noc_pkg::*;

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   logic [DATA_W-1:0]     push_data [NUM_PORTS];
   logic [DATA_W-1:0]     head      [NUM_PORTS];
   logic [CNT_W-1:0]      count     [NUM_PORTS];
   logic [NUM_PORTS-1:0]  push;
   logic [NUM_PORTS-1:0]  pop;
   logic [NUM_PORTS-1:0]  full;
   logic [NUM_PORTS-1:0]  empty;
   logic [NUM_PORTS-1:0]  full_drop;
   logic [NUM_PORTS-1:0]  head_drop;
   logic [NUM_LEAVES-1:0] leaf_ready;

   port_t                 target [NUM_PORTS];
   logic [NUM_PORTS-1:0]  req    [NUM_PORTS];   // req[output][input]
   grant_t                gnt    [NUM_PORTS];
   port_t                 ptr    [NUM_PORTS];
   logic                  up_stage_free;

   logic [NUM_LEAVES*DATA_W-1:0] leaf_data_q;
   logic [NUM_LEAVES-1:0]        leaf_valid_q;
   logic [DATA_W-1:0]            up_data_q;
   logic                         up_valid_q;

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_fifo
      flit_fifo #(
         .DATA_W (DATA_W),
         .DEPTH  (FIFO_DEPTH)
      ) u_fifo (
         .clk       (clk),
         .reset     (reset),
         .push      (push[i]),
         .push_data (push_data[i]),
         .pop       (pop[i]),
         .head      (head[i]),
         .count     (count[i]),
         .full      (full[i]),
         .empty     (empty[i])
      );
   end

   // Input side: leaves get a one-cycle-early ready (NI presents a cycle after
   // sampling it); a leaf flit on a full FIFO is discarded in its arrival cycle.
   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      push      = '0;
      full_drop = '0;
      for (int i = 0; i < NUM_LEAVES; i++) begin
         push_data[i]  = bus.leaf_data_in[i*DATA_W +: DATA_W];
         push[i]       = bus.leaf_valid_in[i] && !full[i];
         full_drop[i]  = bus.leaf_valid_in[i] && full[i];
         leaf_ready[i] = (count[i] <= CNT_W'(FIFO_DEPTH - 2));
      end
      push_data[UPLINK] = bus.up_data_in;
      push[UPLINK]      = bus.up_valid_in && !full[UPLINK];
   end

   assign bus.leaf_ready_out = leaf_ready;
   assign bus.up_ready_out   = (count[UPLINK] != CNT_W'(FIFO_DEPTH));

   // Route decode of every FIFO head: drop, local leaf, or uplink.
   always_comb begin
      head_drop = '0;
      for (int o = 0; o < NUM_PORTS; o++) req[o] = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         target[k] = port_t'(UPLINK);
         if (!empty[k]) begin
            if (head[k][DATA_W-1 -: HEADER_W] == '0) begin
               head_drop[k] = 1'b1;
            end else if (hdr_group(head[k]) == GROUP_ID) begin
               target[k] = {1'b0, hdr_leaf(head[k])};
            end else if (k == UPLINK) begin
               // Spine traffic must belong to this group; anything else is misrouted.
               head_drop[k] = 1'b1;
            end
            if (!head_drop[k]) req[target[k]][k] = 1'b1;
         end
      end
   end

   // Per-output round-robin arbitration; the uplink only grants into a free or draining stage.
   always_comb begin
      up_stage_free = !up_valid_q || bus.up_ready_in;
      pop           = head_drop;
      for (int o = 0; o < NUM_PORTS; o++) begin
         if (o == UPLINK && !up_stage_free) gnt[o] = rr_pick('0, ptr[o]);
         else                               gnt[o] = rr_pick(req[o], ptr[o]);
         if (gnt[o].found) pop[gnt[o].idx] = 1'b1;
      end
   end

   assign drop_pulse = head_drop | full_drop;

   // Arbiter pointers advance one past each winner and hold otherwise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int o = 0; o < NUM_PORTS; o++) ptr[o] <= '0;
      end else begin
         for (int o = 0; o < NUM_PORTS; o++) begin
            if (gnt[o].found) ptr[o] <= next_ptr(gnt[o].idx);
         end
      end
   end

   // Leaf output registers: one-cycle valid pulse per grant, data holds between grants.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         leaf_valid_q <= '0;
         leaf_data_q  <= '0;
      end else begin
         for (int o = 0; o < NUM_LEAVES; o++) begin
            leaf_valid_q[o] <= gnt[o].found;
            if (gnt[o].found) leaf_data_q[o*DATA_W +: DATA_W] <= head[gnt[o].idx];
         end
      end
   end

   // Uplink output stage: load on grant, hold while stalled, clear once accepted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         up_valid_q <= 1'b0;
         up_data_q  <= '0;
      end else if (gnt[UPLINK].found) begin
         up_valid_q <= 1'b1;
         up_data_q  <= head[gnt[UPLINK].idx];
      end else if (bus.up_ready_in) begin
         up_valid_q <= 1'b0;
      end
   end

   assign bus.leaf_valid_out = leaf_valid_q;
   assign bus.leaf_data_out  = leaf_data_q;
   assign bus.up_valid_out   = up_valid_q;
   assign bus.up_data_out    = up_data_q;

endmodule

// File: tb/tb_group_leaf_router.sv
// Scoreboard bench for group_leaf_router (GROUP_ID 4): expected flits are
// queued per output when driven and compared when the output fires.
module tb_group_leaf_router;
   import noc_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] drop_pulse;

   always #5 clk = ~clk;

   group_leaf_router_if #(.DATA_W(16)) bus ();

   group_leaf_router #(
      .GROUP_ID   (4'd4),
      .DATA_W     (16),
      .HEADER_W   (6),
      .FIFO_DEPTH (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .drop_pulse (drop_pulse)
   );

   int          errors = 0;
   int          checks = 0;
   logic [15:0] exp_leaf [4][$];
   logic [15:0] exp_up [$];
   int          drop_seen [5];
   int          drop_exp [5];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Output monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (!reset) begin
         for (int o = 0; o < 4; o++) begin
            if (bus.leaf_valid_out[o]) begin
               check($sformatf("leaf%0d_pending", o), 32'(exp_leaf[o].size() != 0), 32'd1);
               if (exp_leaf[o].size() != 0)
                  check($sformatf("leaf%0d_data", o), 32'(bus.leaf_data_out[o*16 +: 16]),
                        32'(exp_leaf[o].pop_front()));
            end
         end
         if (bus.up_valid_out && bus.up_ready_in) begin
            check("up_pending", 32'(exp_up.size() != 0), 32'd1);
            if (exp_up.size() != 0)
               check("up_data", 32'(bus.up_data_out), 32'(exp_up.pop_front()));
         end
         for (int i = 0; i < 5; i++) if (drop_pulse[i]) drop_seen[i]++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.leaf_valid_in = '0;
      bus.up_valid_in   = 1'b0;
   endtask

   // Drain n cycles, then require every queue empty and drop counts matched.
   task automatic settle(input string tag, input int n);
      repeat (n) tick();
      for (int o = 0; o < 4; o++)
         check($sformatf("%s_leaf%0d_left", tag, o), 32'(exp_leaf[o].size()), 32'd0);
      check($sformatf("%s_up_left", tag), 32'(exp_up.size()), 32'd0);
      for (int i = 0; i < 5; i++)
         check($sformatf("%s_drops%0d", tag, i), 32'(drop_seen[i]), 32'(drop_exp[i]));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int          sent;
      logic        pend;
      logic [15:0] flit;

      for (int i = 0; i < 5; i++) begin
         drop_seen[i] = 0;
         drop_exp[i]  = 0;
      end
      reset             = 1'b1;
      bus.leaf_data_in  = '0;
      bus.leaf_valid_in = '0;
      bus.up_data_in    = '0;
      bus.up_valid_in   = 1'b0;
      bus.up_ready_in   = 1'b1;
      repeat (2) tick();

      // Reset state.
      check("rst_leaf_ready", 32'(bus.leaf_ready_out), 32'hF);
      check("rst_up_ready", 32'(bus.up_ready_out), 32'd1);
      check("rst_leaf_valid", 32'(bus.leaf_valid_out), 32'd0);
      check("rst_leaf_data", 32'(bus.leaf_data_out[31:0]), 32'd0);
      check("rst_up_valid", 32'(bus.up_valid_out), 32'd0);
      check("rst_up_data", 32'(bus.up_data_out), 32'd0);
      check("rst_drop", 32'(drop_pulse), 32'd0);
      reset = 1'b0;
      tick();

      // Leaf-to-leaf latency: present in cycle 0, output valid in cycle 2.
      bus.leaf_data_in[16 +: 16] = 16'h4403;
      bus.leaf_valid_in          = 4'b0010;
      exp_leaf[1].push_back(16'h4403);
      tick();
      clear_inputs();
      @(posedge clk);
      @(negedge clk);
      check("lat_leaf_valid", 32'(bus.leaf_valid_out), 32'h2);
      #1;
      settle("l2l", 4);

      // Off-group to uplink with a 3-cycle stall.
      bus.up_ready_in          = 1'b0;
      bus.leaf_data_in[0 +: 16] = 16'h2005;
      bus.leaf_valid_in        = 4'b0001;
      exp_up.push_back(16'h2005);
      tick();
      clear_inputs();
      for (int c = 0; c < 10 && !bus.up_valid_out; c++) tick();
      check("up_valid_seen", 32'(bus.up_valid_out), 32'd1);
      check("up_data_first", 32'(bus.up_data_out), 32'h2005);
      for (int c = 0; c < 3; c++) begin
         tick();
         check("up_hold_valid", 32'(bus.up_valid_out), 32'd1);
         check("up_hold_data", 32'(bus.up_data_out), 32'h2005);
      end
      bus.up_ready_in = 1'b1;
      settle("offgrp", 4);

      // Contention on leaf 0: order 0,1,2,3 then (ptr at 4) 0,3.
      for (int i = 0; i < 4; i++) begin
         bus.leaf_data_in[i*16 +: 16] = 16'h4000 | 16'(i);
         exp_leaf[0].push_back(16'h4000 | 16'(i));
      end
      bus.leaf_valid_in = 4'b1111;
      tick();
      clear_inputs();
      settle("cont1", 8);
      bus.leaf_data_in[0 +: 16]  = 16'h4000;
      bus.leaf_data_in[48 +: 16] = 16'h4003;
      bus.leaf_valid_in          = 4'b1001;
      exp_leaf[0].push_back(16'h4000);
      exp_leaf[0].push_back(16'h4003);
      tick();
      clear_inputs();
      settle("cont2", 6);

      // Backpressure: compliant NI2 streams while the spine stalls.
      bus.up_ready_in = 1'b0;
      sent = 0;
      pend = bus.leaf_ready_out[2];
      for (int c = 0; c < 12; c++) begin
         bus.leaf_valid_in[2] = pend;
         if (pend) begin
            flit = 16'h2000 | 16'(sent);
            bus.leaf_data_in[32 +: 16] = flit;
            exp_up.push_back(flit);
            sent++;
         end
         pend = bus.leaf_ready_out[2];
         tick();
      end
      clear_inputs();
      check("bp_sent", 32'(sent), 32'd5);
      check("bp_ready2", 32'(bus.leaf_ready_out[2]), 32'd0);
      check("bp_up_valid", 32'(bus.up_valid_out), 32'd1);
      check("bp_up_data", 32'(bus.up_data_out), 32'h2000);
      bus.up_ready_in = 1'b1;
      settle("bp", 10);

      // Drops: misrouted spine flit, zero header on leaf 3; local spine flit to leaf 3.
      bus.up_data_in             = 16'h3000;
      bus.up_valid_in            = 1'b1;
      bus.leaf_data_in[48 +: 16] = 16'h03FF;
      bus.leaf_valid_in          = 4'b1000;
      drop_exp[4]++;
      drop_exp[3]++;
      tick();
      clear_inputs();
      bus.up_data_in  = 16'h4C00;
      bus.up_valid_in = 1'b1;
      exp_leaf[3].push_back(16'h4C00);
      tick();
      clear_inputs();
      settle("drop", 5);

      // Non-compliant NI2 ignores ready: the sixth flit lands on a full FIFO.
      bus.up_ready_in = 1'b0;
      for (int c = 0; c < 6; c++) begin
         flit = 16'h2100 | 16'(c);
         bus.leaf_data_in[32 +: 16] = flit;
         bus.leaf_valid_in          = 4'b0100;
         if (c < 5) exp_up.push_back(flit);
         else       drop_exp[2]++;
         tick();
      end
      clear_inputs();
      bus.up_ready_in = 1'b1;
      settle("fulldrop", 10);

      // Reset with flits in flight: stage holds one, FIFO holds three.
      bus.up_ready_in = 1'b0;
      for (int c = 0; c < 4; c++) begin
         bus.leaf_data_in[32 +: 16] = 16'h2200 | 16'(c);
         bus.leaf_valid_in          = 4'b0100;
         tick();
      end
      clear_inputs();
      check("pre_rst_up_valid", 32'(bus.up_valid_out), 32'd1);
      reset = 1'b1;
      tick();
      check("mid_rst_leaf_valid", 32'(bus.leaf_valid_out), 32'd0);
      check("mid_rst_up_valid", 32'(bus.up_valid_out), 32'd0);
      check("mid_rst_leaf_ready", 32'(bus.leaf_ready_out), 32'hF);
      check("mid_rst_up_ready", 32'(bus.up_ready_out), 32'd1);
      check("mid_rst_up_data", 32'(bus.up_data_out), 32'd0);
      reset           = 1'b0;
      bus.up_ready_in = 1'b1;
      settle("post_rst_quiet", 10);
      bus.leaf_data_in[32 +: 16] = 16'h2111;
      bus.leaf_valid_in          = 4'b0100;
      exp_up.push_back(16'h2111);
      tick();
      clear_inputs();
      settle("post_rst", 5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
